// File: rtl/pong_pkg.sv
// ==================================================================
// pong_pkg : shared widths, requester indices and arbiter states
// Rev 1.0
// ==================================================================
`default_nettype none

package pong_pkg;

   localparam int VGA_XW = 8;
   localparam int VGA_YW = 7;
   localparam int VGA_CW = 3;

   localparam int REQ_BALL    = 0;
   localparam int REQ_PAD_BOT = 1;
   localparam int REQ_PAD_TOP = 2;
   localparam int REQ_SCORE   = 3;

   typedef enum logic [1:0] {
      ARB_IDLE    = 2'd0,
      ARB_GRANT   = 2'd1,
      ARB_RELEASE = 2'd2
   } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/vga_draw_arbiter_rr_select.sv
// ==================================================================
// rr_select : combinational round-robin pick, searching from ptr+1
// Rev 1.0
// ==================================================================
`default_nettype none

module rr_select #(
   parameter int N_REQ = 4,
   parameter int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic [N_REQ-1:0] req,
   input  logic [PW-1:0]    ptr,
   output logic [N_REQ-1:0] sel,
   output logic [PW-1:0]    sel_idx
);

   logic          found;
   logic [PW-1:0] cand;

   always_comb begin
      sel     = '0;
      sel_idx = '0;
      found   = 1'b0;
      cand    = '0;
      for (int i = 1; i <= N_REQ; i++) begin
         cand = PW'((int'(ptr) + i) % N_REQ);
         if (!found && req[cand]) begin
            found     = 1'b1;
            sel[cand] = 1'b1;
            sel_idx   = cand;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/vga_draw_arbiter.sv
// ==================================================================
// vga_draw_arbiter : round-robin owner of the shared VGA plot port.
// ARB_TIMEOUT_EN adds a grant watchdog and the sticky timeout_err.
// Rev 1.0
// ==================================================================
`default_nettype none

module vga_draw_arbiter
   import pong_pkg::*;
#(
   parameter int N_REQ   = 4,
   parameter int XW      = VGA_XW,
   parameter int YW      = VGA_YW,
   parameter int CW      = VGA_CW,
   parameter int TIMEOUT = 64
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [N_REQ-1:0]    req,
   input  logic [N_REQ-1:0]    last,
   input  logic [N_REQ-1:0]    plot_in,
   input  logic [N_REQ*XW-1:0] x_in,
   input  logic [N_REQ*YW-1:0] y_in,
   input  logic [N_REQ*CW-1:0] color_in,
   output logic [N_REQ-1:0]    grant,
   output logic [XW-1:0]       x_out,
   output logic [YW-1:0]       y_out,
   output logic [CW-1:0]       color_out,
   output logic                writeEn,
   output logic                busy
`ifdef ARB_TIMEOUT_EN
   ,
   output logic                timeout_err
`endif
);

   localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   arb_state_e       state_q, state_d;
   logic [PW-1:0]    ptr_q, ptr_d;
   logic [N_REQ-1:0] grant_q, grant_d;
   logic [XW-1:0]    x_q, x_d;
   logic [YW-1:0]    y_q, y_d;
   logic [CW-1:0]    color_q, color_d;
   logic             we_q, we_d;
   logic             busy_q, busy_d;

   logic [N_REQ-1:0] rr_sel;
   logic [PW-1:0]    rr_idx;

   logic [XW-1:0]    x_arr     [N_REQ];
   logic [YW-1:0]    y_arr     [N_REQ];
   logic [CW-1:0]    color_arr [N_REQ];

`ifdef ARB_TIMEOUT_EN
   localparam int CNTW = $clog2(TIMEOUT + 1);
   logic [CNTW-1:0] cnt_q, cnt_d;
   logic            terr_q, terr_d;
`else
   logic            unused_timeout;
   assign unused_timeout = (TIMEOUT == 0);
`endif

   generate
      for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
         assign x_arr[gi]     = x_in[gi*XW +: XW];
         assign y_arr[gi]     = y_in[gi*YW +: YW];
         assign color_arr[gi] = color_in[gi*CW +: CW];
      end
   endgenerate

   rr_select #(
      .N_REQ   (N_REQ),
      .PW      (PW)
   ) u_rr_select (
      .req     (req),
      .ptr     (ptr_q),
      .sel     (rr_sel),
      .sel_idx (rr_idx)
   );

   // While granted, ptr_q doubles as the index of the current owner.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      grant_d = grant_q;
      x_d     = x_q;
      y_d     = y_q;
      color_d = color_q;
      we_d    = 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt_d   = cnt_q;
      terr_d  = terr_q;
`endif
      case (state_q)
         ARB_IDLE: begin
            if (|req) begin
               grant_d = rr_sel;
               ptr_d   = rr_idx;
               state_d = ARB_GRANT;
`ifdef ARB_TIMEOUT_EN
               cnt_d   = '0;
`endif
            end
         end
         ARB_GRANT: begin
            x_d     = x_arr[ptr_q];
            y_d     = y_arr[ptr_q];
            color_d = color_arr[ptr_q];
            we_d    = plot_in[ptr_q];
`ifdef ARB_TIMEOUT_EN
            cnt_d   = cnt_q + CNTW'(1);
`endif
            if (last[ptr_q]) begin
               grant_d = '0;
               state_d = ARB_RELEASE;
            end else if (!req[ptr_q]) begin
               grant_d = '0;
               we_d    = 1'b0;
               state_d = ARB_RELEASE;
            end
`ifdef ARB_TIMEOUT_EN
            else if (cnt_q == CNTW'(TIMEOUT - 1)) begin
               grant_d = '0;
               we_d    = 1'b0;
               terr_d  = 1'b1;
               state_d = ARB_RELEASE;
            end
`endif
         end
         ARB_RELEASE: state_d = ARB_IDLE;
         default:     state_d = ARB_IDLE;
      endcase
      busy_d = (state_d != ARB_IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ARB_IDLE;
         ptr_q   <= PW'(N_REQ - 1);
         grant_q <= '0;
         x_q     <= '0;
         y_q     <= '0;
         color_q <= '0;
         we_q    <= 1'b0;
         busy_q  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
         cnt_q   <= '0;
         terr_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         grant_q <= grant_d;
         x_q     <= x_d;
         y_q     <= y_d;
         color_q <= color_d;
         we_q    <= we_d;
         busy_q  <= busy_d;
`ifdef ARB_TIMEOUT_EN
         cnt_q   <= cnt_d;
         terr_q  <= terr_d;
`endif
      end
   end

   assign grant     = grant_q;
   assign x_out     = x_q;
   assign y_out     = y_q;
   assign color_out = color_q;
   assign writeEn   = we_q;
   assign busy      = busy_q;
`ifdef ARB_TIMEOUT_EN
   assign timeout_err = terr_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_vga_draw_arbiter.sv
// ==================================================================
// tb_vga_draw_arbiter : directed bench with a transaction-level model
// Rev 1.0
// ==================================================================
`default_nettype none

module tb_vga_draw_arbiter;
   import pong_pkg::*;

   localparam int N  = 4;
   localparam int XW = 8;
   localparam int YW = 7;
   localparam int CW = 3;
   localparam int TO = 8;

   logic            clk = 1'b0;
   logic            reset = 1'b0;
   logic [N-1:0]    req = '0, last = '0, plot_in = '0;
   logic [N*XW-1:0] x_in = '0;
   logic [N*YW-1:0] y_in = '0;
   logic [N*CW-1:0] color_in = '0;
   wire  [N-1:0]    grant;
   wire  [XW-1:0]   x_out;
   wire  [YW-1:0]   y_out;
   wire  [CW-1:0]   color_out;
   wire             writeEn, busy;
`ifdef ARB_TIMEOUT_EN
   wire             timeout_err;
`endif

   vga_draw_arbiter #(.N_REQ(N), .XW(XW), .YW(YW), .CW(CW), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .req(req), .last(last), .plot_in(plot_in),
      .x_in(x_in), .y_in(y_in), .color_in(color_in), .grant(grant),
      .x_out(x_out), .y_out(y_out), .color_out(color_out),
      .writeEn(writeEn), .busy(busy)
`ifdef ARB_TIMEOUT_EN
      , .timeout_err(timeout_err)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Requester behaviour: each streams a 4-wide sprite once granted.
   int bursts_left[N], pix_len[N], pix_idx[N], abort_at[N];
   int base_x[N], base_y[N], col[N];
   bit no_last[N];

   always @(negedge clk) begin
      for (int i = 0; i < N; i++) begin
         if (grant[i] === 1'b1 && req[i]) begin
            if (abort_at[i] >= 0 && pix_idx[i] == abort_at[i]) begin
               req[i] = 1'b0; plot_in[i] = 1'b0; last[i] = 1'b0; bursts_left[i] = 0;
            end else begin
               plot_in[i] = 1'b1;
               x_in[i*XW +: XW]     = XW'(base_x[i] + pix_idx[i] % 4);
               y_in[i*YW +: YW]     = YW'(base_y[i] + pix_idx[i] / 4);
               color_in[i*CW +: CW] = CW'(col[i]);
               last[i] = !no_last[i] && (pix_idx[i] == pix_len[i] - 1);
               if (last[i]) begin
                  bursts_left[i]--; pix_idx[i] = 0;
               end else begin
                  pix_idx[i]++;
               end
            end
         end else begin
            plot_in[i] = 1'b0; last[i] = 1'b0; req[i] = (bursts_left[i] > 0);
         end
      end
   end

   // Transaction-level model: one owner at a time, one-cycle release gap.
   int         m_owner = -1, m_ptr = N - 1, m_tcnt = 0, m_cand;
   bit         m_rel = 0, m_valid = 0, m_zero = 0;
   logic [N-1:0]  e_grant = '0;
   logic          e_we = 0, e_busy = 0, e_terr = 0;
   logic [XW-1:0] e_x = '0;
   logic [YW-1:0] e_y = '0;
   logic [CW-1:0] e_c = '0;

   always @(posedge clk) begin
      if (reset) begin
         m_valid = 1; m_owner = -1; m_rel = 0; m_ptr = N - 1; m_zero = 1;
         e_grant = '0; e_we = 0; e_busy = 0; e_terr = 0;
      end else if (m_valid) begin
         if (m_rel) begin
            m_rel = 0; e_we = 0; e_busy = 0; e_grant = '0;
         end else if (m_owner < 0) begin
            e_we = 0; e_grant = '0; e_busy = 0;
            for (int k = 1; k <= N; k++) begin
               m_cand = (m_ptr + k) % N;
               if (m_owner < 0 && req[m_cand]) m_owner = m_cand;
            end
            if (m_owner >= 0) begin
               m_ptr = m_owner; e_grant = N'(1 << m_owner); e_busy = 1; m_tcnt = 0;
            end
         end else begin
            m_zero = 0; e_busy = 1;
            if (last[m_owner]) begin
               e_we = plot_in[m_owner];
               e_x = x_in[m_owner*XW +: XW]; e_y = y_in[m_owner*YW +: YW];
               e_c = color_in[m_owner*CW +: CW];
               m_owner = -1; m_rel = 1; e_grant = '0;
            end else if (!req[m_owner]) begin
               e_we = 0; m_owner = -1; m_rel = 1; e_grant = '0;
            end
`ifdef ARB_TIMEOUT_EN
            else if (m_tcnt == TO - 1) begin
               e_we = 0; e_terr = 1; m_owner = -1; m_rel = 1; e_grant = '0;
            end
`endif
            else begin
               e_we = plot_in[m_owner];
               e_x = x_in[m_owner*XW +: XW]; e_y = y_in[m_owner*YW +: YW];
               e_c = color_in[m_owner*CW +: CW];
               m_tcnt++;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         chk("grant", grant, e_grant);
         chk("writeEn", writeEn, e_we);
         chk("busy", busy, e_busy);
         if (e_we) begin
            chk("x_out", x_out, e_x);
            chk("y_out", y_out, e_y);
            chk("color_out", color_out, e_c);
         end
         if (m_zero) begin
            chk("x_rst", x_out, 0);
            chk("y_rst", y_out, 0);
            chk("c_rst", color_out, 0);
         end
`ifdef ARB_TIMEOUT_EN
         chk("timeout_err", timeout_err, e_terr);
`endif
      end
   end

   // Burst bookkeeping used by the literal expectations.
   logic [N-1:0]  prev_grant = '0;
   int            order[$], gaps[$];
   int            wr_count = 0, zrun = 0;
   bit            seen_we = 0;
   logic [XW-1:0] lw_x = '0;
   logic [YW-1:0] lw_y = '0;
   logic [CW-1:0] lw_c = '0;

   always @(negedge clk) begin
      if (grant !== '0 && prev_grant === '0)
         for (int k = 0; k < N; k++) if (grant[k] === 1'b1) order.push_back(k);
      prev_grant = grant;
      if (writeEn === 1'b1) begin
         if (seen_we && zrun > 0) gaps.push_back(zrun);
         seen_we = 1; zrun = 0; wr_count++;
         lw_x = x_out; lw_y = y_out; lw_c = color_out;
      end else begin
         zrun++;
      end
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic clear_mon();
      order.delete(); gaps.delete(); wr_count = 0; zrun = 0; seen_we = 0;
   endtask

   task automatic clear_req();
      for (int i = 0; i < N; i++) begin
         bursts_left[i] = 0; pix_idx[i] = 0; abort_at[i] = -1; no_last[i] = 0;
         pix_len[i] = 4; base_x[i] = 10 * i; base_y[i] = 5 * i; col[i] = i + 1;
      end
   endtask

   task automatic do_reset();
      clear_req();
      reset = 1'b1; step(); reset = 1'b0;
      clear_mon();
   endtask

   task automatic wait_done(input int budget);
      bit done;
      done = 0;
      for (int n = 0; n < budget && !done; n++) begin
         step();
         done = (grant === '0) && (busy === 1'b0);
         for (int i = 0; i < N; i++) if (bursts_left[i] != 0) done = 0;
      end
      if (!done) begin
         checks++; failures++;
         $display("FAIL wait_done: bursts not drained within %0d cycles", budget);
      end
   endtask

   int exp_rr[5];
   int hold;

   initial begin
      clear_req();
      reset = 1'b1; step(); step(); reset = 1'b0;

      chk("rst_grant", grant, 0);
      chk("rst_writeEn", writeEn, 0);
      chk("rst_busy", busy, 0);
      chk("rst_x", x_out, 0);
      for (int n = 0; n < 10; n++) begin
         step();
         chk("idle_grant", grant, 0);
         chk("idle_writeEn", writeEn, 0);
      end

      // Single 16-pixel burst from the ball.
      clear_mon();
      base_x[REQ_BALL] = 80; base_y[REQ_BALL] = 60; col[REQ_BALL] = 5;
      pix_len[REQ_BALL] = 16; bursts_left[REQ_BALL] = 1;
      step();
      chk("first_grant", grant, 4'b0001);
      wait_done(300);
      chk("burst_writes", wr_count, 16);
      chk("burst_last_x", lw_x, 83);
      chk("burst_last_y", lw_y, 63);
      chk("burst_last_c", lw_c, 3'b101);

      // Round robin with every requester asserting.
      do_reset();
      bursts_left[REQ_BALL] = 2;
      bursts_left[REQ_PAD_BOT] = 1; bursts_left[REQ_PAD_TOP] = 1; bursts_left[REQ_SCORE] = 1;
      wait_done(400);
      exp_rr = '{REQ_BALL, REQ_PAD_BOT, REQ_PAD_TOP, REQ_SCORE, REQ_BALL};
      chk("rr_count", order.size(), 5);
      for (int k = 0; k < 5; k++) chk("rr_order", (k < order.size()) ? order[k] : -1, exp_rr[k]);
      chk("rr_gap_count", gaps.size(), 4);
      foreach (gaps[k]) chk("rr_gap", gaps[k], 2);
      chk("rr_writes", wr_count, 20);

      // Top paddle abandons its burst after 5 pixels.
      do_reset();
      pix_len[REQ_PAD_TOP] = 8; abort_at[REQ_PAD_TOP] = 5; bursts_left[REQ_PAD_TOP] = 1;
      bursts_left[REQ_SCORE] = 1;
      wait_done(300);
      chk("abort_count", order.size(), 2);
      chk("abort_first", (order.size() > 0) ? order[0] : -1, REQ_PAD_TOP);
      chk("abort_next", (order.size() > 1) ? order[1] : -1, REQ_SCORE);
      chk("abort_writes", wr_count, 9);

      // Reset lands on pixel 7 of the bottom paddle.
      do_reset();
      pix_len[REQ_PAD_BOT] = 16; bursts_left[REQ_PAD_BOT] = 1;
      for (int n = 0; n < 100 && !(grant[REQ_PAD_BOT] === 1'b1 && pix_idx[REQ_PAD_BOT] == 6); n++)
         step();
      chk("pix7_reached", (grant[REQ_PAD_BOT] === 1'b1 && pix_idx[REQ_PAD_BOT] == 6), 1);
      reset = 1'b1; step();
      chk("midrst_grant", grant, 0);
      chk("midrst_writeEn", writeEn, 0);
      reset = 1'b0;
      clear_req(); clear_mon();
      bursts_left[REQ_BALL] = 1; bursts_left[REQ_PAD_BOT] = 1; bursts_left[REQ_PAD_TOP] = 1;
      wait_done(300);
      chk("midrst_count", order.size(), 3);
      chk("midrst_first", (order.size() > 0) ? order[0] : -1, REQ_BALL);

`ifdef ARB_TIMEOUT_EN
      // Score display never sends last.
      do_reset();
      no_last[REQ_SCORE] = 1; bursts_left[REQ_SCORE] = 1;
      for (int n = 0; n < 50 && grant[REQ_SCORE] !== 1'b1; n++) step();
      chk("to_granted", grant[REQ_SCORE], 1);
      bursts_left[REQ_BALL] = 1;
      hold = 0;
      for (int n = 0; n < 100 && grant[REQ_SCORE] === 1'b1; n++) begin
         hold++; step();
      end
      chk("to_hold_cycles", hold, TO);
      chk("to_err_set", timeout_err, 1);
      bursts_left[REQ_SCORE] = 0; no_last[REQ_SCORE] = 0; pix_idx[REQ_SCORE] = 0;
      wait_done(200);
      chk("to_count", order.size(), 2);
      chk("to_next", (order.size() > 1) ? order[1] : -1, REQ_BALL);
      chk("to_err_sticky", timeout_err, 1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
